model_share_sequencer: RTL and testbench
========================================

Name: model_share_sequencer

Overview:
- Time-shares one instance of the shared `model` cell between NUM_REQ requesters.
- Round-robin arbitration selects one requester at a time.
- For the selected requester, the block drives the model inputs, waits a fixed model latency, captures the outputs and returns them with the requester ID.
- Sits between requester logic and the single `model` instance.
- Preserves the model's mixed bus ranges: i0/o0 are [2:-2] and i1/o1 are [-2:2].

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..8.
- ID_W, 2: requester ID width; must satisfy 2**ID_W >= NUM_REQ.
- LATENCY, 2: cycles from model input drive to valid model output; legal range 1..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester request; held high until acknowledged.
- req_i0  input  5*NUM_REQ  packed i0 operands; slice k = bits [5k+4:5k].
- req_i1  input  5*NUM_REQ  packed i1 operands; slice k = bits [5k+4:5k].
- req_ack  output  NUM_REQ  one-hot, one-cycle pulse in ISSUE.
- model_i0  output  [2:-2]  to model i0.
- model_i1  output  [-2:2]  to model i1.
- model_o0  input  [2:-2]  from model o0.
- model_o1  input  [-2:2]  from model o1.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  ID_W  requester index of the response.
- rsp_o0  output  [2:-2]  captured o0.
- rsp_o1  output  [-2:2]  captured o1.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset is asynchronous and active-low:
  - state=IDLE, rr_ptr=0, wait counter=0.
  - model_i0=0, model_i1=0, req_ack=0, rsp_valid=0, rsp_id=0, rsp_o0=0, rsp_o1=0, busy=0.
- Bit mapping is positional, leftmost to leftmost; numeric indices are not matched.
  - Slice bit 5k+4 -> model_i0[2] and model_i1[-2].
  - Slice bit 5k -> model_i0[-2] and model_i1[2].
  - rsp_o0/rsp_o1 copy model_o0/model_o1 with identical ranges.
- States: IDLE, ISSUE, WAIT, CAPTURE, RESP.
- IDLE:
  - If any req bit is high, grant the first requester at or after rr_ptr, searching upward with wrap.
  - Register the grant index g and that requester's operands into model_i0/model_i1; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (1 cycle):
  - req_ack[g]=1; model inputs are stable.
  - Load counter = LATENCY-1.
  - rr_ptr <= (g+1) mod NUM_REQ; the wrap at NUM_REQ-1 returns to 0.
  - If LATENCY==1, go to CAPTURE; otherwise go to WAIT.
- WAIT: decrement the counter each cycle; leave for CAPTURE when it reaches 0.
- Model inputs hold their values from ISSUE through CAPTURE.
- CAPTURE (1 cycle):
  - Sample model_o0/model_o1 into rsp_o0/rsp_o1; rsp_id=g.
  - Total issue-to-capture distance is exactly LATENCY cycles.
  - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_o0 and rsp_o1 are stable until handshake.
  - Handshake when rsp_valid && rsp_ready: clear rsp_valid next cycle and go to IDLE.
- One transaction is in flight at a time.
- req changes outside IDLE are ignored. A requester dropping req after its ack does not cancel the transaction.
- The next arbitration is the IDLE cycle after RESP, so minimum spacing between acks is LATENCY+3 cycles.
- Reset assertion mid-transaction aborts immediately to the reset values; no response is produced for the aborted request.
- rsp_ready held high: RESP lasts exactly 1 cycle.

Test Plan:
1. Reset with req=4'b1111, then release:
   - req_ack order across four transactions is 0,1,2,3.
   - Then 0 again; rr_ptr wraps from 3 to 0.
2. req=4'b0001, req_i0 slice0=5'b10000, req_i1 slice0=5'b10000:
   - model_i0[2]=1 with other bits 0; model_i1[-2]=1 with other bits 0.
   - Model stub returns o0=i0 and o1=i1 after 2 cycles; rsp_o0[2]=1, rsp_o1[-2]=1, rsp_id=0.
3. LATENCY=2: measure the ack cycle to the rsp_valid rise.
   - Latency is exactly 3 cycles with LATENCY=2.
   - Repeat with LATENCY=1: exactly 2 cycles.
4. rsp_ready=0 for 5 cycles while in RESP:
   - rsp_valid, rsp_id and rsp_o0/rsp_o1 stay stable; no new req_ack.
   - Raise rsp_ready: rsp_valid falls the next cycle.
5. Deassert rst_n during WAIT:
   - All outputs go to 0 asynchronously, before the next clock edge.
   - After release, a pending req=4'b0100 is granted to requester 2, since rr_ptr reset to 0 and requesters 0-1 are idle.
6. req=4'b1001 with rr_ptr=1:
   - First grant is 3.
   - After completion, the next grant is 0 (wrap), even though requester 3 still requests.

Source files
------------

// File: rtl/model_share_sequencer.sv
// -----------------------------------------------------------------------------
// model_share_sequencer
//
// Time-shares a single `model` cell between NUM_REQ requesters. A round-robin
// arbiter picks one requester, its operands are driven onto the model inputs,
// the block waits LATENCY cycles, captures the model outputs and presents
// them with the requester ID on a valid/ready response port. Only one
// transaction is in flight at a time.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req[NUM_REQ]        per-requester request, held until acknowledged
//   req_i0/req_i1       packed 5-bit operands, slice k = bits [5k+4:5k]
//   req_ack[NUM_REQ]    one-hot, one-cycle acknowledge (ISSUE state)
//   model_i0 [2:-2]     operand to model i0
//   model_i1 [-2:2]     operand to model i1
//   model_o0 [2:-2]     result from model o0
//   model_o1 [-2:2]     result from model o1
//   rsp_valid/ready     response handshake
//   rsp_id              requester index of the response
//   rsp_o0/rsp_o1       captured model results
//   busy                high whenever the sequencer is not idle
//
// Bus mapping is positional: the leftmost operand bit (5k+4) lands on
// model_i0[2] and on model_i1[-2].
// -----------------------------------------------------------------------------
module model_share_sequencer #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [5*NUM_REQ-1:0]   req_i0,
    input  logic [5*NUM_REQ-1:0]   req_i1,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic [2:-2]            model_i0,
    output logic [-2:2]            model_i1,
    input  logic [2:-2]            model_o0,
    input  logic [-2:2]            model_o1,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [2:-2]            rsp_o0,
    output logic [-2:2]            rsp_o1,
    output logic                   busy
);

    // Sum of pointer and offset needs one extra bit before the modulo wrap.
    localparam int CW = ID_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_RESP
    } state_e;

    state_e          state_q,   state_d;
    logic [ID_W-1:0] rr_ptr_q,  rr_ptr_d;
    logic [ID_W-1:0] grant_q,   grant_d;
    logic [3:0]      cnt_q,     cnt_d;
    logic [2:-2]     mi0_q,     mi0_d;
    logic [-2:2]     mi1_q,     mi1_d;
    logic [ID_W-1:0] rsp_id_q,  rsp_id_d;
    logic [2:-2]     rsp_o0_q,  rsp_o0_d;
    logic [-2:2]     rsp_o1_q,  rsp_o1_d;

    // Per-requester operand slices.
    logic [4:0] op_i0 [NUM_REQ];
    logic [4:0] op_i1 [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign op_i0[gi] = req_i0[5*gi+4 -: 5];
            assign op_i1[gi] = req_i1[5*gi+4 -: 5];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin search: first requesting index at or after rr_ptr, with
    // wrap. Offsets are scanned from the farthest down to the nearest so
    // the nearest hit is the last (winning) assignment.
    // ------------------------------------------------------------------
    logic            arb_found;
    logic [ID_W-1:0] arb_idx;
    logic [CW-1:0]   arb_sum;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_sum   = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            arb_sum = {1'b0, rr_ptr_q} + CW'(off);
            if (arb_sum >= CW'(NUM_REQ)) begin
                arb_sum = arb_sum - CW'(NUM_REQ);
            end
            if (req[arb_sum[ID_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = arb_sum[ID_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
            mi0_q    <= '0;
            mi1_q    <= '0;
            rsp_id_q <= '0;
            rsp_o0_q <= '0;
            rsp_o1_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            mi0_q    <= mi0_d;
            mi1_q    <= mi1_d;
            rsp_id_q <= rsp_id_d;
            rsp_o0_q <= rsp_o0_d;
            rsp_o1_q <= rsp_o1_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        mi0_d    = mi0_q;
        mi1_d    = mi1_q;
        rsp_id_d = rsp_id_q;
        rsp_o0_d = rsp_o0_q;
        rsp_o1_d = rsp_o1_q;

        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    grant_d = arb_idx;
                    mi0_d   = op_i0[arb_idx];
                    mi1_d   = op_i1[arb_idx];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d    = 4'(LATENCY - 1);
                rr_ptr_d = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                state_d  = (LATENCY == 1) ? S_CAPTURE : S_WAIT;
            end
            S_WAIT: begin
                // WAIT lasts LATENCY-1 cycles so ISSUE-to-CAPTURE is LATENCY.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                rsp_o0_d = model_o0;
                rsp_o1_d = model_o1;
                rsp_id_d = grant_q;
                state_d  = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ack
            assign req_ack[gi] = (state_q == S_ISSUE) && (grant_q == ID_W'(gi));
        end
    endgenerate

    assign model_i0  = mi0_q;
    assign model_i1  = mi1_q;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_o0    = rsp_o0_q;
    assign rsp_o1    = rsp_o1_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_model_share_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for model_share_sequencer. The main DUT uses LATENCY=2 with a
// two-stage model stub (o0=i0, o1=i1); a second DUT with LATENCY=1 and a
// one-stage stub is used for the short-latency timing case. Expected acks
// and responses are queued by the stimulus and checked by a monitor.
// -----------------------------------------------------------------------------
module tb_model_share_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  req;
    logic [19:0] req_i0, req_i1;
    logic [3:0]  req_ack;
    logic [2:-2] model_i0, model_o0, rsp_o0;
    logic [-2:2] model_i1, model_o1, rsp_o1;
    logic        rsp_valid, rsp_ready, busy;
    logic [1:0]  rsp_id;

    logic [3:0]  req_b;
    logic [3:0]  req_ack_b;
    logic [2:-2] model_i0_b, model_o0_b, rsp_o0_b;
    logic [-2:2] model_i1_b, model_o1_b, rsp_o1_b;
    logic        rsp_valid_b, rsp_ready_b, busy_b;
    logic [1:0]  rsp_id_b;

    model_share_sequencer #(.NUM_REQ(4), .ID_W(2), .LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_i0(req_i0), .req_i1(req_i1),
        .req_ack(req_ack), .model_i0(model_i0), .model_i1(model_i1),
        .model_o0(model_o0), .model_o1(model_o1), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_o0(rsp_o0),
        .rsp_o1(rsp_o1), .busy(busy)
    );

    model_share_sequencer #(.NUM_REQ(4), .ID_W(2), .LATENCY(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .req_i0(req_i0), .req_i1(req_i1),
        .req_ack(req_ack_b), .model_i0(model_i0_b), .model_i1(model_i1_b),
        .model_o0(model_o0_b), .model_o1(model_o1_b), .rsp_valid(rsp_valid_b),
        .rsp_ready(rsp_ready_b), .rsp_id(rsp_id_b), .rsp_o0(rsp_o0_b),
        .rsp_o1(rsp_o1_b), .busy(busy_b)
    );

    // Model stubs: identity with 2-cycle and 1-cycle latency.
    logic [2:-2] s0_q, s0_qq, sb0_q;
    logic [-2:2] s1_q, s1_qq, sb1_q;
    always @(posedge clk) begin
        s0_q  <= model_i0;   s0_qq <= s0_q;
        s1_q  <= model_i1;   s1_qq <= s1_q;
        sb0_q <= model_i0_b; sb1_q <= model_i1_b;
    end
    assign model_o0   = s0_qq;
    assign model_o1   = s1_qq;
    assign model_o0_b = sb0_q;
    assign model_o1_b = sb1_q;

    // Operand table; slice k of the packed buses.
    logic [4:0] op0 [4] = '{5'b10000, 5'b01011, 5'b10110, 5'b00111};
    logic [4:0] op1 [4] = '{5'b10000, 5'b11001, 5'b00011, 5'b01101};

    typedef struct {
        int         id;
        logic [4:0] o0;
        logic [4:0] o1;
    } rsp_t;

    rsp_t rsp_q[$];
    int   ack_q[$];

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int k);
        rsp_t r;
        r.id = k;
        r.o0 = op0[k];
        r.o1 = op1[k];
        ack_q.push_back(k);
        rsp_q.push_back(r);
    endtask

    // ------------------------------------------------------------------
    // Monitor: checks every ack and every response handshake
    // ------------------------------------------------------------------
    initial begin : monitor
        int         e;
        rsp_t       r;
        logic [4:0] t0, t1;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (req_ack != 4'b0) begin
                    if (ack_q.size() == 0) begin
                        chk("unexpected_ack", int'(req_ack), 0);
                    end else begin
                        e = ack_q.pop_front();
                        chk("ack_onehot", int'(req_ack), 1 << e);
                    end
                end
                if (rsp_valid && rsp_ready) begin
                    t0 = rsp_o0;
                    t1 = rsp_o1;
                    if (rsp_q.size() == 0) begin
                        chk("unexpected_rsp", 1, 0);
                    end else begin
                        r = rsp_q.pop_front();
                        chk("rsp_id", int'(rsp_id), r.id);
                        chk("rsp_o0", int'(t0), int'(r.o0));
                        chk("rsp_o1", int'(t1), int'(r.o1));
                        $display("txn id=%0d o0=%b o1=%b (exp id=%0d o0=%b o1=%b)",
                                 rsp_id, t0, t1, r.id, r.o0, r.o1);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic wait_ack(output int idx);
        idx = -1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (req_ack != 4'b0) begin
                for (int k = 0; k < 4; k++) begin
                    if (req_ack[k]) idx = k;
                end
                return;
            end
        end
        chk("ack_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (!busy) return;
        end
        chk("idle_timeout", 0, 1);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) return;
        end
        chk("valid_timeout", 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        logic [4:0] a, b, c, d;
        a = model_i0; b = model_i1; c = rsp_o0; d = rsp_o1;
        chk({tag, "_busy"},      int'(busy), 0);
        chk({tag, "_req_ack"},   int'(req_ack), 0);
        chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
        chk({tag, "_rsp_id"},    int'(rsp_id), 0);
        chk({tag, "_model_i0"},  int'(a), 0);
        chk({tag, "_model_i1"},  int'(b), 0);
        chk({tag, "_rsp_o0"},    int'(c), 0);
        chk({tag, "_rsp_o1"},    int'(d), 0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : stim
        int         g, lat;
        logic [4:0] t;

        for (int k = 0; k < 4; k++) begin
            req_i0[5*k +: 5] = op0[k];
            req_i1[5*k +: 5] = op1[k];
        end
        rst_n       = 1'b0;
        req         = 4'b1111;
        rsp_ready   = 1'b1;
        req_b       = 4'b0000;
        rsp_ready_b = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // 1: all requesting; grants 0,1,2,3 then wrap to 0
        push(0); push(1); push(2); push(3); push(0);
        rst_n = 1'b1;
        for (int n = 0; n < 5; n++) wait_ack(g);
        req = 4'b0000;
        wait_idle();

        // 2: positional bit mapping through the model stub (rr_ptr now 1)
        push(0);
        req = 4'b0001;
        wait_ack(g);
        req = 4'b0000;
        t = model_i0;
        chk("t2_model_i0", int'(t), 5'b10000);
        t = model_i1;
        chk("t2_model_i1", int'(t), 5'b10000);
        chk("t2_mi0_bit2", int'(model_i0[2]), 1);
        chk("t2_mi1_bitm2", int'(model_i1[-2]), 1);
        wait_valid(lat);
        chk("t2_rsp_o0_bit2", int'(rsp_o0[2]), 1);
        chk("t2_rsp_o1_bitm2", int'(rsp_o1[-2]), 1);
        wait_idle();

        // 3: ack-to-valid latency, LATENCY=2 (rr_ptr 1 -> grant 1)
        push(1);
        req = 4'b0010;
        wait_ack(g);
        req = 4'b0000;
        wait_valid(lat);
        chk("t3_latency_L2", lat, 3);
        wait_idle();

        // 3b: LATENCY=1 instance
        req_b = 4'b0001;
        g = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ack_b != 4'b0) begin
                g = 0;
                break;
            end
        end
        chk("t3_ack_L1", int'(req_ack_b), 1);
        req_b = 4'b0000;
        lat = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid_b) break;
        end
        chk("t3_latency_L1", lat, 2);
        t = rsp_o0_b;
        chk("t3_L1_rsp_o0", int'(t), int'(op0[0]));
        t = rsp_o1_b;
        chk("t3_L1_rsp_o1", int'(t), int'(op1[0]));
        chk("t3_L1_rsp_id", int'(rsp_id_b), 0);

        // 4: back-pressure in RESP (rr_ptr 2 -> grant 2)
        rsp_ready = 1'b0;
        push(2);
        req = 4'b0100;
        wait_ack(g);
        req = 4'b0000;
        wait_valid(lat);
        req = 4'b0001;  // must not be acknowledged while stalled
        for (int n = 0; n < 5; n++) begin
            t = rsp_o0;
            chk("t4_hold_valid", int'(rsp_valid), 1);
            chk("t4_hold_id", int'(rsp_id), 2);
            chk("t4_hold_o0", int'(t), int'(op0[2]));
            t = rsp_o1;
            chk("t4_hold_o1", int'(t), int'(op1[2]));
            chk("t4_no_ack", int'(req_ack), 0);
            if (n < 4) @(negedge clk);
        end
        push(0);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);   // handshake sampled here
        @(negedge clk);
        chk("t4_valid_fall", int'(rsp_valid), 0);
        wait_ack(g);
        req = 4'b0000;
        wait_idle();

        // 5: reset during WAIT (rr_ptr 1 -> grant 1), then grant 2
        ack_q.push_back(1);
        req = 4'b0010;
        wait_ack(g);
        req = 4'b0000;
        @(posedge clk);   // now in WAIT
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("t5_async");
        @(negedge clk);
        rst_n = 1'b1;
        push(2);
        req = 4'b0100;
        wait_ack(g);
        req = 4'b0000;
        wait_idle();

        // 6: rr_ptr 3 -> grant 0 sets rr_ptr 1; then req=1001 grants 3, 0
        push(0);
        req = 4'b0001;
        wait_ack(g);
        req = 4'b0000;
        wait_idle();
        push(3); push(0);
        req = 4'b1001;
        wait_ack(g);
        wait_ack(g);
        req = 4'b0000;
        wait_idle();

        repeat (5) @(negedge clk);
        chk("ack_queue_drained", ack_q.size(), 0);
        chk("rsp_queue_drained", rsp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
